// File: rtl/execute_muldiv_unit.sv
// ============================================================================
// Module   : execute_muldiv_unit
// Purpose  : Iterative multiply/divide unit holding the architectural hi/lo
//            registers in the execute stage. MULTU uses shift-add and DIVU
//            uses restoring division, one bit per cycle (WIDTH cycles per
//            operation). MTHI/MTLO writes are applied in a single edge.
// Ports    : clk, rst_n (async, active-low)
//            Estart/Eop/Esrca/Esrcb - issue strobe, opcode and operands
//            Ereadhilo              - execute-stage instruction reads hi/lo
//            Eflush                 - synchronous abort of in-flight op
//            Ehi/Elo                - registered hi/lo
//            Ebusy/Estall           - in-flight flag / hazard stall request
//            Edone/Edivzero         - one-cycle completion / div-by-zero pulses
// Options  : `define MULDIV_SIGNED_EN adds input Esigned; when high at accept,
//            MULTU/DIVU operate on two's complement operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_muldiv_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Estart,
    input  logic [1:0]       Eop,
    input  logic [WIDTH-1:0] Esrca,
    input  logic [WIDTH-1:0] Esrcb,
`ifdef MULDIV_SIGNED_EN
    input  logic             Esigned,
`endif
    input  logic             Ereadhilo,
    input  logic             Eflush,
    output logic [WIDTH-1:0] Ehi,
    output logic [WIDTH-1:0] Elo,
    output logic             Ebusy,
    output logic             Estall,
    output logic             Edone,
    output logic             Edivzero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] opb;      // multiplicand / divisor magnitude
    logic [WIDTH-1:0] acc;      // product high half / partial remainder
    logic [WIDTH-1:0] quo;      // multiplier shifting out / quotient shifting in
    logic             neg_res;  // negate product or quotient at final edge
    logic             neg_rem;  // negate remainder at final edge

    // Signed-mode operand magnitudes, computed at accept time
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

`ifdef MULDIV_SIGNED_EN
    assign signed_op = Esigned;
`else
    assign signed_op = 1'b0;
`endif

    assign a_neg = signed_op & Esrca[WIDTH-1];
    assign b_neg = signed_op & Esrcb[WIDTH-1];
    assign mag_a = a_neg ? (~Esrca + 1'b1) : Esrca;
    assign mag_b = b_neg ? (~Esrcb + 1'b1) : Esrcb;

    // One iteration of each algorithm
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_acc;
    logic [WIDTH-1:0]   mul_quo;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   div_acc;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   step_acc;
    logic [WIDTH-1:0]   step_quo;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0]   quo_res;
    logic [WIDTH-1:0]   rem_res;

    always_comb begin
        // Shift-add: add multiplicand when the multiplier LSB is set, then
        // shift the combined {acc, quo} right by one.
        mul_sum = {1'b0, acc} + (quo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        mul_acc = mul_sum[WIDTH:1];
        mul_quo = {mul_sum[0], quo[WIDTH-1:1]};

        // Restoring division: bring in the next dividend bit and subtract;
        // the borrow bit (MSB of the difference) decides restore vs keep.
        div_shift = {acc, quo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
        if (!div_diff[WIDTH]) begin
            div_acc = div_diff[WIDTH-1:0];
            div_quo = {quo[WIDTH-2:0], 1'b1};
        end else begin
            div_acc = div_shift[WIDTH-1:0];
            div_quo = {quo[WIDTH-2:0], 1'b0};
        end

        if (state == DIV) begin
            step_acc = div_acc;
            step_quo = div_quo;
        end else begin
            step_acc = mul_acc;
            step_quo = mul_quo;
        end

        // Sign fix-up applied only on the final write
        prod_mag = {mul_acc, mul_quo};
        prod_res = neg_res ? (~prod_mag + 1'b1) : prod_mag;
        quo_res  = neg_res ? (~div_quo + 1'b1) : div_quo;
        rem_res  = neg_rem ? (~div_acc + 1'b1) : div_acc;
    end

    assign Ebusy  = (state != IDLE);
    assign Estall = Ebusy && (Estart || Ereadhilo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            opb      <= '0;
            acc      <= '0;
            quo      <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            Ehi      <= '0;
            Elo      <= '0;
            Edone    <= 1'b0;
            Edivzero <= 1'b0;
        end else begin
            Edone    <= 1'b0;
            Edivzero <= 1'b0;
            case (state)
                IDLE: begin
                    if (Estart && !Eflush) begin
                        case (Eop)
                            OP_MTHI: Ehi <= Esrca;
                            OP_MTLO: Elo <= Esrca;
                            OP_MULTU: begin
                                acc     <= '0;
                                quo     <= mag_a;
                                opb     <= mag_b;
                                neg_res <= a_neg ^ b_neg;
                                neg_rem <= 1'b0;
                                count   <= CW'(WIDTH);
                                state   <= MUL;
                            end
                            OP_DIVU: begin
                                if (Esrcb == '0) begin
                                    // Zero divisor resolves immediately
                                    Ehi      <= Esrca;
                                    Elo      <= '1;
                                    Edone    <= 1'b1;
                                    Edivzero <= 1'b1;
                                end else begin
                                    acc     <= '0;
                                    quo     <= mag_a;
                                    opb     <= mag_b;
                                    neg_res <= a_neg ^ b_neg;
                                    neg_rem <= a_neg;
                                    count   <= CW'(WIDTH);
                                    state   <= DIV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    if (Eflush) begin
                        state <= IDLE;
                        count <= '0;
                    end else begin
                        count <= count - 1'b1;
                        acc   <= step_acc;
                        quo   <= step_quo;
                        if (count == CW'(1)) begin
                            if (state == MUL) begin
                                Ehi <= prod_res[2*WIDTH-1:WIDTH];
                                Elo <= prod_res[WIDTH-1:0];
                            end else begin
                                Ehi <= rem_res;
                                Elo <= quo_res;
                            end
                            Edone <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_execute_muldiv_unit.sv
// ============================================================================
// Module   : tb_execute_muldiv_unit
// Purpose  : Self-checking bench for execute_muldiv_unit. A behavioural model
//            (plain arithmetic plus a busy-cycle countdown) is compared with
//            the DUT on every falling edge; directed tests add literal checks.
// Options  : honours `define MULDIV_SIGNED_EN (drives Esigned, signed tests).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_muldiv_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         Estart = 1'b0;
    logic [1:0]   Eop = 2'b00;
    logic [W-1:0] Esrca = '0;
    logic [W-1:0] Esrcb = '0;
    logic         sgn = 1'b0;
    logic         Ereadhilo = 1'b0;
    logic         Eflush = 1'b0;
    logic [W-1:0] Ehi;
    logic [W-1:0] Elo;
    logic         Ebusy;
    logic         Estall;
    logic         Edone;
    logic         Edivzero;

    always #5 clk = ~clk;

    execute_muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Estart    (Estart),
        .Eop       (Eop),
        .Esrca     (Esrca),
        .Esrcb     (Esrcb),
`ifdef MULDIV_SIGNED_EN
        .Esigned   (sgn),
`endif
        .Ereadhilo (Ereadhilo),
        .Eflush    (Eflush),
        .Ehi       (Ehi),
        .Elo       (Elo),
        .Ebusy     (Ebusy),
        .Estall    (Estall),
        .Edone     (Edone),
        .Edivzero  (Edivzero)
    );

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int           m_rem = 0;
    logic         m_done = 1'b0, m_dz = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        logic [31:0] p;
        int sa, sb;
        if (!rst_n) begin
            m_hi <= '0; m_lo <= '0; m_rem <= 0; m_done <= 1'b0; m_dz <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_rem != 0) begin
                if (Eflush) m_rem <= 0;
                else begin
                    m_rem <= m_rem - 1;
                    if (m_rem == 1) begin
                        m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1;
                    end
                end
            end else if (Estart && !Eflush) begin
                sa = sgn ? int'($signed(Esrca)) : int'(Esrca);
                sb = sgn ? int'($signed(Esrcb)) : int'(Esrcb);
                case (Eop)
                    2'b10: m_hi <= Esrca;
                    2'b11: m_lo <= Esrca;
                    2'b00: begin
                        p = 32'(sa * sb);
                        p_hi <= p[31:16]; p_lo <= p[15:0]; m_rem <= W;
                    end
                    default: begin
                        if (Esrcb == '0) begin
                            m_hi <= Esrca; m_lo <= '1; m_done <= 1'b1; m_dz <= 1'b1;
                        end else begin
                            p = 32'(sa / sb);
                            p_lo <= p[15:0];
                            p = 32'(sa % sb);
                            p_hi <= p[15:0];
                            m_rem <= W;
                        end
                    end
                endcase
            end
        end
    end

    // Cycle-by-cycle comparison, away from the active edge
    always @(negedge clk) begin
        check("Ebusy",    {31'd0, Ebusy},    {31'd0, m_rem != 0});
        check("Edone",    {31'd0, Edone},    {31'd0, m_done});
        check("Edivzero", {31'd0, Edivzero}, {31'd0, m_dz});
        check("Ehi",      {16'd0, Ehi},      {16'd0, m_hi});
        check("Elo",      {16'd0, Elo},      {16'd0, m_lo});
        check("Estall",   {31'd0, Estall},   {31'd0, (m_rem != 0) && (Estart || Ereadhilo)});
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(posedge clk); #2;
        Estart = 1'b1; Eop = op; Esrca = a; Esrcb = b; sgn = s;
        @(posedge clk); #2;
        Estart = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, output int nb, output logic dz);
        logic seen;
        issue(op, a, b, s);
        nb = 0; dz = 1'b0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Ebusy) nb++;
            if (Edone) begin
                dz = Edivzero; seen = 1'b1;
                break;
            end
        end
        check("done_within_bound", {31'd0, seen}, 32'd1);
    endtask

    initial begin : stim
        int nb, st;
        logic dz, s;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_Ehi", {16'd0, Ehi}, 32'd0);
        check("rst_Elo", {16'd0, Elo}, 32'd0);
        check("rst_Ebusy", {31'd0, Ebusy}, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        // MULTU
        run_op(2'b00, 16'h1234, 16'h0010, 1'b0, nb, dz);
        check("mul1_busy_cycles", nb, 16);
        check("mul1_hi", {16'd0, Ehi}, 32'h0001);
        check("mul1_lo", {16'd0, Elo}, 32'h2340);
        run_op(2'b00, 16'hFFFF, 16'hFFFF, 1'b0, nb, dz);
        check("mul2_hi", {16'd0, Ehi}, 32'hFFFE);
        check("mul2_lo", {16'd0, Elo}, 32'h0001);

        // DIVU
        run_op(2'b01, 16'd100, 16'd7, 1'b0, nb, dz);
        check("div1_busy_cycles", nb, 16);
        check("div1_lo", {16'd0, Elo}, 32'h000E);
        check("div1_hi", {16'd0, Ehi}, 32'h0002);
        check("div1_dz", {31'd0, dz}, 32'd0);
        run_op(2'b01, 16'h0055, 16'h0000, 1'b0, nb, dz);
        check("div0_busy_cycles", nb, 0);
        check("div0_dz", {31'd0, dz}, 32'd1);
        check("div0_hi", {16'd0, Ehi}, 32'h0055);
        check("div0_lo", {16'd0, Elo}, 32'hFFFF);

        // Flush in busy cycle 5, then immediate re-issue
        issue(2'b00, 16'd3, 16'd5, 1'b0);
        repeat (4) @(posedge clk);
        #2 Eflush = 1'b1;
        @(posedge clk); #2;
        Eflush = 1'b0;
        Estart = 1'b1; Eop = 2'b11; Esrca = 16'h2222;
        @(posedge clk); #2;
        Estart = 1'b0;
        @(negedge clk);
        check("flush_busy", {31'd0, Ebusy}, 32'd0);
        check("flush_hi_kept", {16'd0, Ehi}, 32'h0055);
        check("flush_mtlo", {16'd0, Elo}, 32'h2222);

        // Ereadhilo during MUL stalls every busy cycle, not the done cycle
        Ereadhilo = 1'b1;
        issue(2'b00, 16'd2, 16'd3, 1'b0);
        st = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Estall) st++;
            if (Edone) break;
        end
        check("readhilo_stall_cycles", st, 16);
        check("stall_in_done_cycle", {31'd0, Estall}, 32'd0);
        @(negedge clk);
        check("readhilo_idle_stall", {31'd0, Estall}, 32'd0);
        Ereadhilo = 1'b0;

        // MTHI presented while busy is held off until IDLE
        issue(2'b00, 16'h0010, 16'h0010, 1'b0);
        Estart = 1'b1; Eop = 2'b10; Esrca = 16'hBEEF;
        st = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            s = Estall;
            if (s) st++;
            @(posedge clk); #2;
            if (!s) break;
        end
        Estart = 1'b0;
        check("mthi_stall_cycles", st, 16);
        @(negedge clk);
        check("mthi_hi", {16'd0, Ehi}, 32'hBEEF);
        check("mthi_lo", {16'd0, Elo}, 32'h0100);

        // Asynchronous reset mid-MUL
        issue(2'b00, 16'd7, 16'd9, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_hi", {16'd0, Ehi}, 32'd0);
        check("async_rst_lo", {16'd0, Elo}, 32'd0);
        check("async_rst_busy", {31'd0, Ebusy}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        st = 0;
        repeat (4) begin
            @(negedge clk);
            if (Edone || Ebusy) st++;
        end
        check("post_rst_quiet", st, 0);

`ifdef MULDIV_SIGNED_EN
        run_op(2'b00, 16'hFFFA, 16'd7, 1'b1, nb, dz);
        check("smul_busy_cycles", nb, 16);
        check("smul_hi", {16'd0, Ehi}, 32'hFFFF);
        check("smul_lo", {16'd0, Elo}, 32'hFFD6);
        run_op(2'b01, 16'hFFF9, 16'd2, 1'b1, nb, dz);
        check("sdiv_busy_cycles", nb, 16);
        check("sdiv_lo", {16'd0, Elo}, 32'hFFFD);
        check("sdiv_hi", {16'd0, Ehi}, 32'hFFFF);
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
